muldiv_unit: RTL and testbench

//   Iterative RISC-V M-extension multiply/divide unit beside the single-cycle ALU in the execute stage.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small arithmetic helpers used by the result fix-up.
package muldiv_pkg;

    // funct3 encodings of the M-extension ops (in_op_i[2:0])
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // in_op_i bit selecting the 32-bit word variant on RV64
    localparam int MD_WORD_BIT = 3;

    // Widest value the helpers handle: a full 2*64-bit product
    localparam int MD_MAXW = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Two's-complement negate; callers zero-extend in and truncate out
    function automatic logic [MD_MAXW-1:0] negate(input logic [MD_MAXW-1:0] x);
        return ~x + MD_MAXW'(1);
    endfunction

    // Sign-extend a 32-bit word result to 64 bits
    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared datapath. The 2*XLEN accumulator is
// {hi, lo}: for multiply hi is the partial product and lo the remaining
// multiplier bits; for divide hi is the partial remainder and lo shifts the
// dividend out at the top while quotient bits enter at the bottom.
module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_nx;
    logic            unused_diff_bit;

    assign hi = acc_i[2*XLEN-1:XLEN];
    assign lo = acc_i[XLEN-1:0];

    // Multiply: add multiplicand when the current multiplier bit is set, then shift right
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : '0);

    // Divide: restoring trial subtract on the (XLEN+1)-bit shifted remainder
    assign rem_sh = {hi, lo[XLEN-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, opnd_i};
    assign q_bit  = ~diff[XLEN+1];
    // A kept remainder is always below the divisor, so XLEN bits suffice
    assign rem_nx = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign unused_diff_bit = diff[XLEN];

    assign acc_o = is_div_i ? {rem_nx, lo[XLEN-2:0], q_bit}
                            : {mul_sum, lo[XLEN-1:1]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready
// handshake, tag passthrough and flush.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a new op
//   CALC    | UNROLL shift-add / trial-subtract steps per cycle
//   FIX     | sign fix-up, half/quotient/remainder select, word sign-extend
//   DONE    | result held on out_result_o until out_ready_i
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_op_i,
    input  logic [XLEN-1:0]  in_a_i,
    input  logic [XLEN-1:0]  in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);

    localparam int N_FULL = XLEN / UNROLL;
    localparam int N_WORD = 32 / UNROLL;
    localparam int CNT_W  = $clog2(N_FULL) + 1;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]    opnd_q, opnd_d;
    logic [2:0]         f3_q, f3_d;
    logic               word_q, word_d;
    logic               neg_q, neg_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    // Request decode
    logic [2:0]         f3_in;
    logic               word_in;
    logic               a_sgn_in, b_sgn_in;
    logic [XLEN-1:0]    a_ext, b_ext, a_mag, b_mag, a_wres;
    logic               a_neg, b_neg;
    logic               div_zero_in, ovf_in, fast_in;
    logic [XLEN-1:0]    fast_res;

    assign f3_in    = in_op_i[2:0];
    assign word_in  = (XLEN == 64) && in_op_i[MD_WORD_BIT]
                      && ((f3_in == MD_MUL) || f3_in[2]);
    assign a_sgn_in = (f3_in == MD_MULH) || (f3_in == MD_MULHSU)
                      || (f3_in == MD_DIV) || (f3_in == MD_REM);
    assign b_sgn_in = (f3_in == MD_MULH) || (f3_in == MD_DIV) || (f3_in == MD_REM);

    // Word ops see only the low 32 bits, extended per the op's signedness
    assign a_ext = word_in ? (a_sgn_in ? XLEN'(sext32(in_a_i[31:0])) : XLEN'(in_a_i[31:0]))
                           : in_a_i;
    assign b_ext = word_in ? (b_sgn_in ? XLEN'(sext32(in_b_i[31:0])) : XLEN'(in_b_i[31:0]))
                           : in_b_i;
    assign a_neg = a_sgn_in && a_ext[XLEN-1];
    assign b_neg = b_sgn_in && b_ext[XLEN-1];
    assign a_mag = a_neg ? XLEN'(negate(MD_MAXW'(a_ext))) : a_ext;
    assign b_mag = b_neg ? XLEN'(negate(MD_MAXW'(b_ext))) : b_ext;

    // Divide special cases resolved without iterating
    assign a_wres      = word_in ? XLEN'(sext32(in_a_i[31:0])) : in_a_i;
    assign div_zero_in = (b_ext == '0);
    assign ovf_in      = ((f3_in == MD_DIV) || (f3_in == MD_REM))
                         && (word_in ? ((in_a_i[31:0] == 32'h8000_0000) && (in_b_i[31:0] == 32'hFFFF_FFFF))
                                     : ((in_a_i == XMIN) && (in_b_i == '1)));
    assign fast_in     = f3_in[2] && (div_zero_in || ovf_in);
    assign fast_res    = div_zero_in ? (f3_in[1] ? a_wres : '1)
                                     : (f3_in[1] ? '0 : a_wres);

    // Unrolled step chain
    logic [2*XLEN-1:0] chain [UNROLL+1];
    assign chain[0] = acc_q;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div_i (f3_q[2]),
            .acc_i    (chain[gi]),
            .opnd_i   (opnd_q),
            .acc_o    (chain[gi+1])
        );
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   dv_sel, dv_fix, fix_res;

    // Result fix-up: sign correction, then pick half / quotient / remainder
    always_comb begin
        prod_fix = neg_q ? (2*XLEN)'(negate(MD_MAXW'(acc_q))) : acc_q;
        dv_sel   = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        dv_fix   = neg_q ? XLEN'(negate(MD_MAXW'(dv_sel))) : dv_sel;
        if (f3_q[2]) begin
            fix_res = word_q ? XLEN'(sext32(dv_fix[31:0])) : dv_fix;
        end else if (f3_q == MD_MUL) begin
            // a word multiply ran 32 steps, leaving its product 32 bits up
            fix_res = word_q ? XLEN'(sext32(prod_fix[XLEN-1 -: 32])) : prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath-load logic; flush overrides everything but reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        f3_d    = f3_q;
        word_d  = word_q;
        neg_d   = neg_q;
        res_d   = res_q;
        tag_d   = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    f3_d   = f3_in;
                    word_d = word_in;
                    tag_d  = in_tag_i;
                    if (fast_in) begin
                        res_d   = fast_res;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = word_in ? CNT_W'(N_WORD - 1) : CNT_W'(N_FULL - 1);
                        if (f3_in[2]) begin
                            // word dividend sits at the top of lo so 32 steps consume it
                            acc_d  = {{XLEN{1'b0}}, (word_in ? (a_mag << (XLEN - 32)) : a_mag)};
                            opnd_d = b_mag;
                            neg_d  = f3_in[1] ? a_neg : (a_neg ^ b_neg);
                        end else begin
                            acc_d  = {{XLEN{1'b0}}, b_mag};
                            opnd_d = a_mag;
                            neg_d  = a_neg ^ b_neg;
                        end
                    end
                end
            end
            ST_CALC: begin
                acc_d = chain[UNROLL];
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                res_d   = fix_res;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            f3_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            f3_q    <= f3_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready_o   = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign out_valid_o  = (state_q == ST_DONE);
    assign out_result_o = res_q;
    assign out_tag_o    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an RV32 instance for the main op set and
// an RV64 instance for full-width and word variants.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        out_ready;
    logic [3:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [4:0]  in_tag;

    logic        in_valid32, in_ready32, out_valid32, busy32;
    logic [31:0] res32;
    logic [4:0]  tag32;

    logic        in_valid64, in_ready64, out_valid64, busy64;
    logic [63:0] res64;
    logic [4:0]  tag64;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(32), .UNROLL(1), .TAG_W(5)) u_dut32 (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid32),
        .in_ready_o   (in_ready32),
        .in_op_i      (in_op),
        .in_a_i       (in_a[31:0]),
        .in_b_i       (in_b[31:0]),
        .in_tag_i     (in_tag),
        .out_valid_o  (out_valid32),
        .out_ready_i  (out_ready),
        .out_result_o (res32),
        .out_tag_o    (tag32),
        .busy_o       (busy32)
    );

    muldiv_unit #(.XLEN(64), .UNROLL(1), .TAG_W(5)) u_dut64 (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid64),
        .in_ready_o   (in_ready64),
        .in_op_i      (in_op),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .in_tag_i     (in_tag),
        .out_valid_o  (out_valid64),
        .out_ready_i  (out_ready),
        .out_result_o (res64),
        .out_tag_o    (tag64),
        .busy_o       (busy64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    // Issue one op, measure edges from the accept edge until out_valid shows,
    // check result/tag, optionally stall in DONE, then retire it.
    task automatic run_op(input bit w64, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag, input int exp_lat,
                          input logic [63:0] exp_res, input int hold, input string nm);
        int lat;
        @(negedge clk);
        chk({nm, "_rdy"}, 64'(w64 ? in_ready64 : in_ready32), 64'd1);
        in_op  = op;
        in_a   = a;
        in_b   = b;
        in_tag = tag;
        if (w64) in_valid64 = 1'b1;
        else     in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        lat = 0;
        while (!(w64 ? out_valid64 : out_valid32) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_res"}, w64 ? res64 : {32'b0, res32}, exp_res);
        chk({nm, "_tag"}, 64'(w64 ? tag64 : tag32), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({nm, "_hold_v"}, 64'(out_valid32), 64'd1);
            chk({nm, "_hold_res"}, {32'b0, res32}, exp_res);
            chk({nm, "_hold_rdy"}, 64'(in_ready32), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, "_ret_rdy"}, 64'(w64 ? in_ready64 : in_ready32), 64'd1);
        chk({nm, "_ret_v"}, 64'(w64 ? out_valid64 : out_valid32), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        bit saw;
        rst        = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        in_op      = 4'h0;
        in_a       = '0;
        in_b       = '0;
        in_tag     = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready32), 64'd1);
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_result", {32'b0, res32}, 64'd0);
        chk("rst_tag", 64'(tag32), 64'd0);
        chk("rst64_out_valid", 64'(out_valid64), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Iterative ops on RV32: DONE registered 33 edges after the accept edge
        run_op(0, 4'h0, 64'd7,          64'hFFFF_FFFD, 5'd9,  33, 64'hFFFF_FFEB, 0, "mul");
        run_op(0, 4'h1, 64'h8000_0000,  64'h8000_0000, 5'd1,  33, 64'h4000_0000, 0, "mulh");
        run_op(0, 4'h2, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 5'd2,  33, 64'hFFFF_FFFF, 0, "mulhsu");
        run_op(0, 4'h3, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 5'd3,  33, 64'hFFFF_FFFE, 0, "mulhu");
        run_op(0, 4'h4, 64'hFFFF_FFF9,  64'd2,         5'd4,  33, 64'hFFFF_FFFD, 0, "div");
        run_op(0, 4'h6, 64'hFFFF_FFF9,  64'd2,         5'd5,  33, 64'hFFFF_FFFF, 0, "rem");
        run_op(0, 4'h5, 64'd100,        64'd7,         5'd6,  33, 64'd14,        0, "divu");
        run_op(0, 4'h7, 64'd100,        64'd7,         5'd7,  33, 64'd2,         0, "remu");

        // Fast path: valid straight off the accept edge
        run_op(0, 4'h4, 64'h1234,       64'd0,         5'd10, 0,  64'hFFFF_FFFF, 0, "div_by0");
        run_op(0, 4'h6, 64'd5,          64'd0,         5'd11, 0,  64'd5,         0, "rem_by0");
        run_op(0, 4'h4, 64'h8000_0000,  64'hFFFF_FFFF, 5'd12, 0,  64'h8000_0000, 0, "div_ovf");
        run_op(0, 4'h6, 64'h8000_0000,  64'hFFFF_FFFF, 5'd13, 0,  64'd0,         0, "rem_ovf");

        // Consumer stall for 10 cycles in DONE
        run_op(0, 4'h5, 64'd100,        64'd7,         5'd14, 33, 64'd14,        10, "stall");

        // Flush after 5 CALC steps
        @(negedge clk);
        in_op = 4'h0; in_a = 64'd7; in_b = 64'd3; in_tag = 5'd20;
        in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_rdy", 64'(in_ready32), 64'd1);
        chk("flush_busy", 64'(busy32), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid32) saw = 1'b1;
        end
        chk("flush_quiet", 64'(saw), 64'd0);

        // Flush together with a request: nothing accepted
        @(negedge clk);
        flush = 1'b1;
        in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_noacc", 64'(busy32), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid32 = 1'b0;

        // Reset after 5 CALC steps
        @(negedge clk);
        in_op = 4'h5; in_a = 64'd50; in_b = 64'd3; in_tag = 5'd21;
        in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rdy", 64'(in_ready32), 64'd1);
        chk("midrst_result", {32'b0, res32}, 64'd0);
        chk("midrst_tag", 64'(tag32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid32) saw = 1'b1;
        end
        chk("midrst_quiet", 64'(saw), 64'd0);

        run_op(0, 4'h5, 64'd9, 64'd3, 5'd22, 33, 64'd3, 0, "divu_after");

        // RV64: full-width op takes 65 edges, word ops 33 or fast path
        run_op(1, 4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd23, 65, 64'hFFFF_FFFF_FFFF_FFEB, 0, "mul64");
        run_op(1, 4'hC, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd24, 0,
               64'hFFFF_FFFF_8000_0000, 0, "divw_ovf");
        run_op(1, 4'hC, 64'h0000_0005_FFFF_FFF9, 64'd2, 5'd25, 33, 64'hFFFF_FFFF_FFFF_FFFD, 0, "divw");
        run_op(1, 4'h8, 64'h0000_0001_7FFF_FFFF, 64'd2, 5'd26, 33, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mulw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
